// File: rtl/burst_out_bus.sv
// Word FIFO feeding a four-phase request/acknowledge beat serialiser.
// Optional acknowledge timeout enabled by defining BURST_OUT_BUS_TIMEOUT_EN.
module burst_out_bus #(
    parameter int PINS           = 8,
    parameter int WORD_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int COUNT_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  in_data,
    output logic                   request,
    input  logic                   acknowledge,
    output logic [PINS-1:0]        out,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] words_sent,
    output logic                   timeout_err
);

    localparam int BEATS = WORD_WIDTH / PINS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK_HI,
        ACK_LO,
        FINISH
    } state_t;

    logic                   ack_m_q, ack_s_q;
    logic [WORD_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] words_sent_q, words_sent_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic                   request_q, request_d;
    logic [PINS-1:0]        out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   push, pop, flush, empty;
    logic [WORD_WIDTH-1:0]  head;
    logic [PINS-1:0]        slice;

    assign empty      = (count_q == '0);
    assign in_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push       = in_valid & in_ready;
    assign head       = mem_q[rd_ptr_q];
    assign request    = request_q;
    assign out        = out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign words_sent = words_sent_q;

    always_comb begin
        slice = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) slice = head[b*PINS +: PINS];
        end
    end

`ifdef BURST_OUT_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_err_q, timeout_err_d;
    logic          in_ack;
    assign timeout_err = timeout_err_q;
    assign in_ack = (state_q == ACK_HI) || (state_q == ACK_LO);
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        words_sent_d = words_sent_q;
        beat_d       = beat_q;
        request_d    = request_q;
        out_d        = out_q;
        done_d       = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
`ifdef BURST_OUT_BUS_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
        tmo_d         = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d        = num_words;
                    words_sent_d = '0;
                    beat_d       = '0;
`ifdef BURST_OUT_BUS_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                    state_d = (num_words == '0) ? FINISH : REQ;
                end
            end
            REQ: begin
                if (!ack_s_q && !empty) begin
                    out_d     = slice;
                    request_d = 1'b1;
                    state_d   = ACK_HI;
                end
            end
            ACK_HI: begin
                if (ack_s_q) begin
                    request_d = 1'b0;
                    state_d   = ACK_LO;
                end
            end
            ACK_LO: begin
                if (!ack_s_q) begin
                    if (beat_q == BW'(BEATS - 1)) begin
                        pop          = 1'b1;
                        words_sent_d = words_sent_q + COUNT_WIDTH'(1);
                        beat_d       = '0;
                        state_d = (words_sent_d == cnt_q) ? FINISH : REQ;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        state_d = REQ;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef BURST_OUT_BUS_TIMEOUT_EN
        // Count only while parked in a handshake state; any move restarts it.
        if (in_ack && state_d == state_q) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_err_d = 1'b1;
                request_d     = 1'b0;
                flush         = 1'b1;
                state_d       = FINISH;
                tmo_d         = '0;
            end
        end
`endif
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) rd_ptr_d = wr_ptr_q;
        else if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (flush) count_d = (AW+1)'(push);
        else count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_m_q      <= 1'b0;
            ack_s_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            words_sent_q <= '0;
            beat_q       <= '0;
            request_q    <= 1'b0;
            out_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef BURST_OUT_BUS_TIMEOUT_EN
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            ack_m_q      <= acknowledge;
            ack_s_q      <= ack_m_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            words_sent_q <= words_sent_d;
            beat_q       <= beat_d;
            request_q    <= request_d;
            out_q        <= out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef BURST_OUT_BUS_TIMEOUT_EN
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_burst_out_bus.sv
// Scoreboard bench for burst_out_bus: expected beats queued at push,
// popped and compared on each request rise.
module tb_burst_out_bus;

    localparam int PINS = 8;
    localparam int WW   = 32;
    localparam int FD   = 4;
    localparam int CW   = 8;
    localparam int TC   = 15;
    localparam int NB   = WW / PINS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_words;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_data;
    logic          request;
    logic          acknowledge;
    logic [PINS-1:0] out;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_sent;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [PINS-1:0] exp_q [$];
    int   rises = 0;
    int   dones = 0;
    logic req_prev = 1'b0;
    logic [PINS-1:0] out_at_rise = '0;
    logic rsp_en = 1'b1;

    burst_out_bus #(
        .PINS(PINS), .WORD_WIDTH(WW), .FIFO_DEPTH(FD),
        .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .request(request), .acknowledge(acknowledge), .out(out),
        .busy(busy), .done(done), .words_sent(words_sent),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && request && !req_prev) begin
                rises++;
                out_at_rise = out;
                if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                else check("beat", out, exp_q.pop_front());
            end
            if (!rst && !request && req_prev)
                check("out_stable", out, out_at_rise);
            if (done) dones++;
            req_prev = request;
        end
    end

    // Receiver: acks each request three cycles after it rises
    initial begin
        acknowledge = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rsp_en && request && !acknowledge) begin
                repeat (3) @(posedge clk);
                #1 acknowledge = 1'b1;
                for (int i = 0; i < 50 && request; i++) begin
                    @(posedge clk); #1;
                end
                acknowledge = 1'b0;
            end
        end
    end

    task automatic push_word(input logic [WW-1:0] w);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            check("push_wait", 0, 1);
        end else begin
            in_valid = 1'b1;
            in_data  = w;
            for (int b = 0; b < NB; b++)
                exp_q.push_back(w[b*PINS +: PINS]);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic start_burst(input logic [CW-1:0] n);
        @(negedge clk);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check(tag, done, 1);
    endtask

    int r0, d0, dcyc, busyc, hic;
    logic seen;

    initial begin
        rst = 1'b1; start = 1'b0; num_words = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_request", request, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words_sent", words_sent, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_out", out, 0);
        rst = 1'b0;

        // Single word, four beats
        r0 = rises; d0 = dones;
        push_word(32'hDDCCBBAA);
        start_burst(1);
        wait_done("s1_done", 400);
        repeat (3) @(negedge clk); #1;
        check("s1_req_pulses", rises - r0, 4);
        check("s1_words_sent", words_sent, 1);
        check("s1_done_pulses", dones - d0, 1);
        check("s1_queue_empty", exp_q.size(), 0);

        // Zero-length burst
        r0 = rises; d0 = dones;
        @(negedge clk);
        start = 1'b1; num_words = '0;
        dcyc = -1; busyc = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busyc++;
            if (done && dcyc < 0) dcyc = i;
        end
        #1;
        check("s2_done_cycle", dcyc, 2);
        check("s2_busy_cycles", busyc, 1);
        check("s2_no_request", rises - r0, 0);
        check("s2_done_pulses", dones - d0, 1);
        check("s2_words_sent", words_sent, 0);

        // Fill the FIFO, then drain it in one burst
        push_word(32'h03020100);
        push_word(32'h13121110);
        push_word(32'h23222120);
        check("s3_not_full", in_ready, 1);
        push_word(32'h33323130);
        check("s3_full", in_ready, 0);
        r0 = rises;
        start_burst(4);
        for (int i = 0; i < 500; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        check("s3_ready_rise", in_ready, 1);
        check("s3_ready_ws", words_sent, 1);
        wait_done("s3_done", 2000);
        repeat (2) @(negedge clk); #1;
        check("s3_req_pulses", rises - r0, 16);
        check("s3_words_sent", words_sent, 4);
        check("s3_queue_empty", exp_q.size(), 0);

        // Empty FIFO stall
        start_burst(2);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (request) seen = 1'b1;
        end
        check("s4_stall", seen, 0);
        check("s4_busy", busy, 1);
        push_word(32'hA5A55A5A);
        push_word(32'h0F0FF0F0);
        wait_done("s4_done", 1000);
        repeat (2) @(negedge clk); #1;
        check("s4_words_sent", words_sent, 2);
        check("s4_queue_empty", exp_q.size(), 0);

        // Reset during beat 2
        push_word(32'h44332211);
        r0 = rises;
        start_burst(1);
        for (int i = 0; i < 300; i++) begin
            #1;
            if (rises == r0 + 3) break;
            @(negedge clk);
        end
        check("s5_reach_beat2", request, 1);
        d0 = dones;
        rst = 1'b1;
        #1;
        check("s5_rst_request", request, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_words_sent", words_sent, 0);
        check("s5_rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        repeat (6) @(negedge clk); #1;
        check("s5_no_done", dones - d0, 0);
        push_word(32'h87654321);
        start_burst(1);
        wait_done("s5_again_done", 400);
        repeat (2) @(negedge clk); #1;
        check("s5_again_ws", words_sent, 1);
        check("s5_queue_empty", exp_q.size(), 0);

        // Receiver never acknowledges
        rsp_en = 1'b0;
        d0 = dones;
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        start_burst(1);
`ifdef BURST_OUT_BUS_TIMEOUT_EN
        hic = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (request) hic++;
            if (done) break;
        end
        check("s6_done", done, 1);
        check("s6_req_cycles", hic, TC);
        @(negedge clk);
        check("s6_timeout_err", timeout_err, 1);
        check("s6_request_low", request, 0);
        exp_q.delete();
        push_word(32'h44444444);
        push_word(32'h55555555);
        push_word(32'h66666666);
        check("s6_flushed", in_ready, 1);
        exp_q.delete();
        start_burst(0);
        check("s6_err_cleared", timeout_err, 0);
        wait_done("s6_zero_done", 20);
`else
        repeat (100) @(negedge clk);
        #1;
        check("s6_request_held", request, 1);
        check("s6_no_timeout", timeout_err, 0);
        check("s6_no_done", dones - d0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $fatal(1, "bench time limit");
    end

endmodule
